mpu_sequencer: RTL and testbench

//   Self-timed controller for one MPU operation. Start sampled -> reads Matrix A

---
 rtl/mpu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mpu_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_sequencer.sv
// Self-timed sequencer for one MPU operation: read A and B from RAM, wait for the datapath, write the result.
// Define MPU_SEQ_STEP_EN to gate every non-IDLE transition on a Step button pulse.
module mpu_sequencer #(
    parameter int unsigned DATA_W = 200,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned OP_LAT = 3
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [2:0]        Op_in,
    input  logic [ADDR_W-1:0] Base_addr,
`ifdef MPU_SEQ_STEP_EN
    input  logic              Step,
`endif
    input  logic [DATA_W-1:0] Mem_q,
    input  logic [DATA_W-1:0] Result_in,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_wren,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic [DATA_W-1:0] Matrix_A,
    output logic [DATA_W-1:0] Matrix_B,
    output logic [2:0]        Op_sel,
    output logic              Busy,
    output logic              Done,
    output logic [2:0]        State
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_LAT_A = 3'd2,
        S_RD_B  = 3'd3,
        S_LAT_B = 3'd4,
        S_EXEC  = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] mat_a_q, mat_a_d;
    logic [DATA_W-1:0] mat_b_q, mat_b_d;
    logic [2:0]        op_sel_q, op_sel_d;
    logic              step_ok;
    logic              advance;

`ifdef MPU_SEQ_STEP_EN
    assign step_ok = Step;
`else
    assign step_ok = 1'b1;
`endif

    // A non-IDLE state leaves only once its latency counter has run out.
    assign advance = (cnt_q == 8'd0) && step_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_wren_d  = mem_wren_q;
        mem_wdata_d = mem_wdata_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        op_sel_d    = op_sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_sel_d   = Op_in;
                    base_d     = Base_addr;
                    mem_addr_d = Base_addr;
                    cnt_d      = 8'd0;
                    state_d    = S_RD_A;
                end
            end
            S_RD_A: begin
                if (advance) begin
                    cnt_d   = 8'(RD_LAT - 1);
                    state_d = S_LAT_A;
                end
            end
            S_LAT_A: begin
                if (advance) begin
                    mat_a_d    = Mem_q;
                    mem_addr_d = base_q + ADDR_W'(1);
                    cnt_d      = 8'd0;
                    state_d    = S_RD_B;
                end
            end
            S_RD_B: begin
                if (advance) begin
                    cnt_d   = 8'(RD_LAT - 1);
                    state_d = S_LAT_B;
                end
            end
            S_LAT_B: begin
                if (advance) begin
                    mat_b_d = Mem_q;
                    cnt_d   = 8'(OP_LAT - 1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    mem_wdata_d = Result_in;
                    mem_addr_d  = base_q + ADDR_W'(2);
                    mem_wren_d  = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (advance) begin
                    mem_wren_d = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (advance) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= '0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            op_sel_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_wren_q  <= mem_wren_d;
            mem_wdata_q <= mem_wdata_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
            op_sel_q    <= op_sel_d;
        end
    end

    assign Mem_addr  = mem_addr_q;
    assign Mem_wren  = mem_wren_q;
    assign Mem_wdata = mem_wdata_q;
    assign Matrix_A  = mat_a_q;
    assign Matrix_B  = mat_b_q;
    assign Op_sel    = op_sel_q;
    assign Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done      = (state_q == S_DONE);
    assign State     = state_q;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Bench for mpu_sequencer: RAM and datapath models around the DUT, operation-level reference model.
module tb_mpu_sequencer;
  localparam int DATA_W   = 200;
  localparam int ADDR_W   = 3;
  localparam int RD_LAT   = 2;
  localparam int OP_LAT   = 3;
  localparam int BUSY_EXP = 2 + 2 * RD_LAT + OP_LAT + 1;
  localparam int RIDX     = (OP_LAT > 1) ? OP_LAT - 2 : 0;
  localparam int NWORDS   = 1 << ADDR_W;

  logic              Clock;
  logic              Reset_n;
  logic              Start;
  logic [2:0]        Op_in;
  logic [ADDR_W-1:0] Base_addr;
`ifdef MPU_SEQ_STEP_EN
  logic              Step;
`endif
  logic [DATA_W-1:0] Mem_q;
  logic [DATA_W-1:0] Result_in;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_wren;
  logic [DATA_W-1:0] Mem_wdata;
  logic [DATA_W-1:0] Matrix_A;
  logic [DATA_W-1:0] Matrix_B;
  logic [2:0]        Op_sel;
  logic              Busy;
  logic              Done;
  logic [2:0]        State;

  mpu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .OP_LAT(OP_LAT)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op_in(Op_in), .Base_addr(Base_addr),
`ifdef MPU_SEQ_STEP_EN
    .Step(Step),
`endif
    .Mem_q(Mem_q), .Result_in(Result_in), .Mem_addr(Mem_addr), .Mem_wren(Mem_wren),
    .Mem_wdata(Mem_wdata), .Matrix_A(Matrix_A), .Matrix_B(Matrix_B), .Op_sel(Op_sel),
    .Busy(Busy), .Done(Done), .State(State)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  int wr_total = 0;
  bit step_mode = 1'b0;

  logic [DATA_W-1:0] mem     [NWORDS];
  logic [DATA_W-1:0] ref_mem [NWORDS];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic [DATA_W-1:0] res_pipe[OP_LAT];
  logic [DATA_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0]  exp_addr_q[$];

  function automatic logic [DATA_W-1:0] mpu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                              input logic [2:0] op);
    case (op[1:0])
      2'd0:    mpu_f = a + b;
      2'd1:    mpu_f = a - b;
      2'd2:    mpu_f = a ^ b;
      default: mpu_f = (a & ~b) + DATA_W'(op);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < (DATA_W + 31) / 32; i++) w = (w << 32) | DATA_W'($urandom);
    return w;
  endfunction

  // RAM with RD_LAT cycles from address to data; datapath with OP_LAT cycles from operands to result
  always @(posedge Clock) begin
    rd_pipe[0] <= mem[Mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (Mem_wren) mem[Mem_addr] <= Mem_wdata;
    res_pipe[0] <= mpu_f(Matrix_A, Matrix_B, Op_sel);
    for (int i = 1; i < OP_LAT; i++) res_pipe[i] <= res_pipe[i-1];
  end
  assign Mem_q     = rd_pipe[RD_LAT-1];
  assign Result_in = (OP_LAT == 1) ? mpu_f(Matrix_A, Matrix_B, Op_sel) : res_pipe[RIDX];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // scoreboard for RAM writes
  always @(negedge Clock) begin
    if (Reset_n && Mem_wren) begin
      check("wren_outside_write", State, 3'd6);
      if (!step_mode) begin
        wr_total++;
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", Mem_addr, exp_addr_q.pop_front());
          check("wr_data", Mem_wdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_state"}, State, 0);
    check({tag, "_wren"}, Mem_wren, 0);
    check({tag, "_addr"}, Mem_addr, 0);
    check({tag, "_wdata"}, Mem_wdata, 0);
    check({tag, "_mat_a"}, Matrix_A, 0);
    check({tag, "_mat_b"}, Matrix_B, 0);
    check({tag, "_op_sel"}, Op_sel, 0);
  endtask

  // driver: one operation; keep holds Start high, after_done means called in the DONE cycle
  task automatic do_op(input logic [ADDR_W-1:0] base, input logic [2:0] op, input bit keep, input bit after_done);
    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] ea, eb, ec;
    int waited, busy_n, wr0;
    bit done_seen;
    a1 = base + 1'b1;
    a2 = base + 2'd2;
    ea = ref_mem[base];
    eb = ref_mem[a1];
    ec = mpu_f(ea, eb, op);
    exp_q.push_back(ec);
    exp_addr_q.push_back(a2);
    wr0 = wr_total;
    Start = 1'b1; Op_in = op; Base_addr = base;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!Busy && waited < 4);
    check("start_gap", waited, after_done ? 2 : 1);
    check("rd_a_addr", Mem_addr, base);
    check("rd_a_state", State, 3'd1);
    busy_n = 1;
    done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (!keep) Start = 1'($urandom_range(0, 1));
      Op_in = 3'($urandom);
      Base_addr = ADDR_W'($urandom);
      tick();
      if (Busy) busy_n++;
      if (Done) done_seen = 1'b1;
    end
    if (!keep) Start = 1'b0;
    check("done_seen", done_seen, 1);
    check("busy_len", busy_n, BUSY_EXP);
    check("done_state", State, 3'd7);
    check("one_write", wr_total - wr0, 1);
    check("matrix_a", Matrix_A, ea);
    check("matrix_b", Matrix_B, eb);
    check("op_sel", Op_sel, op);
    ref_mem[a2] = ec;
    if (!keep) begin
      tick();
      check("done_pulse", Done, 0);
      check("idle_after_done", State, 3'd0);
    end
  endtask

  task automatic reset_during(input logic [2:0] target);
    int n, wr0;
    Start = 1'b1; Op_in = 3'($urandom); Base_addr = ADDR_W'($urandom);
    n = 0;
    do begin
      tick();
      Start = 1'b0;
      n++;
    end while (State != target && n < 30);
    check("reach_state", State, target);
    wr0 = wr_total;
    #1 Reset_n = 1'b0;
    #1 check_all_zero(target == 3'd5 ? "rst_exec" : "rst_write");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    check("no_write_after_rst", wr_total - wr0, 0);
    check("idle_after_rst", State, 3'd0);
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Op_in = '0; Base_addr = '0;
`ifdef MPU_SEQ_STEP_EN
    Step = 1'b1;
`endif
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = rand_word();
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    for (int i = 0; i < OP_LAT; i++) res_pipe[i] = '0;
    repeat (3) tick();
    check_all_zero("reset");
    Reset_n = 1'b1;
    tick();

    do_op(3'd0, 3'b001, 1'b0, 1'b0);
    do_op(3'd7, 3'($urandom), 1'b0, 1'b0);
    do_op(ADDR_W'($urandom), 3'($urandom), 1'b1, 1'b0);
    do_op(ADDR_W'($urandom), 3'($urandom), 1'b1, 1'b1);
    do_op(ADDR_W'($urandom), 3'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) do_op(ADDR_W'($urandom), 3'($urandom), 1'b0, 1'b0);

    reset_during(3'd5);
    do_op(ADDR_W'($urandom), 3'($urandom), 1'b0, 1'b0);
    reset_during(3'd6);
    do_op(ADDR_W'($urandom), 3'($urandom), 1'b0, 1'b0);

`ifdef MPU_SEQ_STEP_EN
    begin
      logic [2:0] exp_st [7];
      exp_st = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      step_mode = 1'b1;
      Step = 1'b0;
      Start = 1'b1; Base_addr = ADDR_W'($urandom); Op_in = 3'($urandom);
      tick();
      Start = 1'b0;
      repeat (20) tick();
      check("step_parked", State, 3'd1);
      for (int p = 0; p < 7; p++) begin
        repeat (4) tick();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        check("step_state", State, exp_st[p]);
        check("step_wren", Mem_wren, (exp_st[p] == 3'd6) ? 1 : 0);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
